// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet byte type, framing constants and receive FSM states
package eth_pkg;

  typedef logic [7:0] TypeByte;

  localparam TypeByte     ETH_PREAMBLE  = 8'h55;
  localparam TypeByte     ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD,
    DROP
  } rx_state_t;

endpackage

// File: rtl/crc32_step_d8.sv
// rtl/crc32_step_d8.sv - one byte of reflected Ethernet CRC32, LSB of the byte first
module crc32_step_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] next
);

  always_comb begin
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ (((c[0] ^ data[i]) == 1'b1) ? CRC32_POLY : 32'h0);
    end
    next = c;
  end

endmodule

// File: rtl/gmii_rx_fcs_checker.sv
// rtl/gmii_rx_fcs_checker.sv - GMII receive framer: strips preamble/SFD, checks FCS, forwards payload
module gmii_rx_fcs_checker
  import eth_pkg::*;
#(
  parameter int MIN_LEN      = 64,
  parameter int MAX_LEN      = 1518,
  parameter int MAX_PREAMBLE = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_dv,
  input  logic        rx_er,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        frame_done,
  output logic        frame_good,
  output logic [15:0] frame_len
);

  localparam int              PRE_W   = $clog2(MAX_PREAMBLE + 2);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(MAX_PREAMBLE);
  localparam logic [15:0]     LEN_MIN = 16'(MIN_LEN);
  localparam logic [15:0]     LEN_MAX = 16'(MAX_LEN);

  rx_state_t        state, state_nxt;
  logic             armed;
  logic [PRE_W-1:0] pre_cnt, pre_inc;
  TypeByte          hold [4];
  logic [2:0]       hold_cnt;
  logic [15:0]      len;
  logic [31:0]      crc, crc_nxt;
  logic             err;
  logic             sof_pending;
  logic             sfd_hit;

  crc32_step_d8 u_crc (
    .crc  (crc),
    .data (rx_data),
    .next (crc_nxt)
  );

  assign pre_inc = pre_cnt + PRE_W'(1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rx_dv && armed) begin
          if (rx_er)                        state_nxt = DROP;
          else if (rx_data == ETH_PREAMBLE) state_nxt = PREAMBLE;
          else if (rx_data == ETH_SFD)      state_nxt = PAYLOAD;
          else                              state_nxt = DROP;
        end
      end
      PREAMBLE: begin
        if (!rx_dv)                         state_nxt = IDLE;
        else if (rx_er)                     state_nxt = DROP;
        else if (rx_data == ETH_PREAMBLE) begin
          if (pre_inc > PRE_MAX)            state_nxt = DROP;
        end
        else if (rx_data == ETH_SFD)        state_nxt = PAYLOAD;
        else                                state_nxt = DROP;
      end
      PAYLOAD: if (!rx_dv) state_nxt = IDLE;
      DROP:    if (!rx_dv) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    sfd_hit = (state != PAYLOAD) && (state_nxt == PAYLOAD);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      armed       <= 1'b0;
      pre_cnt     <= '0;
      hold_cnt    <= '0;
      len         <= '0;
      crc         <= CRC32_INIT;
      err         <= 1'b0;
      sof_pending <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_sof     <= 1'b0;
      frame_done  <= 1'b0;
      frame_good  <= 1'b0;
      frame_len   <= '0;
      for (int i = 0; i < 4; i++) hold[i] <= '0;
    end else begin
      state      <= state_nxt;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      frame_done <= 1'b0;
      if (!rx_dv) armed <= 1'b1;

      if (state == IDLE)          pre_cnt <= PRE_W'(1);
      else if (state == PREAMBLE) pre_cnt <= pre_inc;

      if (sfd_hit) begin
        crc         <= CRC32_INIT;
        len         <= '0;
        err         <= 1'b0;
        hold_cnt    <= '0;
        sof_pending <= 1'b1;
      end

      if (state == PAYLOAD) begin
        if (rx_dv) begin
          crc <= crc_nxt;
          if (len != 16'hFFFF) len <= len + 16'd1;
          if (rx_er) err <= 1'b1;
          // The newest four bytes may turn out to be the FCS, so only older bytes leave.
          if (hold_cnt == 3'd4) begin
            out_data    <= hold[0];
            out_valid   <= 1'b1;
            out_sof     <= sof_pending;
            sof_pending <= 1'b0;
            hold[0]     <= hold[1];
            hold[1]     <= hold[2];
            hold[2]     <= hold[3];
            hold[3]     <= rx_data;
          end else begin
            hold[hold_cnt[1:0]] <= rx_data;
            hold_cnt            <= hold_cnt + 3'd1;
          end
        end else begin
          frame_done <= 1'b1;
          frame_good <= (crc == CRC32_RESIDUE) && !err && (len >= 16'd4) &&
                        (len >= LEN_MIN) && (len <= LEN_MAX);
          frame_len  <= len;
          hold_cnt   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_gmii_rx_fcs_checker.sv
// tb/tb_gmii_rx_fcs_checker.sv - self-checking bench for gmii_rx_fcs_checker
module tb_gmii_rx_fcs_checker;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic        g1;
    logic        g2;
    logic [15:0] len;
    longint      t;
  } done_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_dv, rx_er;
  logic [7:0]  a_out_data, b_out_data;
  logic        a_out_valid, b_out_valid, a_out_sof, b_out_sof;
  logic        a_frame_done, b_frame_done, a_frame_good, b_frame_good;
  logic [15:0] a_frame_len, b_frame_len;

  int checks = 0;
  int errors = 0;

  logic [7:0] drv_d[$];
  logic       drv_dv[$], drv_er[$], drv_rst[$];
  logic [7:0] exp_b[$], got_b[$];
  logic       exp_s[$], got_s[$];
  done_t      exp_done[$], got_done[$];
  longint     last_dv_t;

  gmii_rx_fcs_checker dut_a (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_dv(rx_dv), .rx_er(rx_er),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_sof(a_out_sof),
    .frame_done(a_frame_done), .frame_good(a_frame_good), .frame_len(a_frame_len)
  );

  gmii_rx_fcs_checker #(.MIN_LEN(1)) dut_b (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_dv(rx_dv), .rx_er(rx_er),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_sof(b_out_sof),
    .frame_done(b_frame_done), .frame_good(b_frame_good), .frame_len(b_frame_len)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (a_out_valid) begin
      got_b.push_back(a_out_data);
      got_s.push_back(a_out_sof);
    end
    if (a_frame_done || b_frame_done)
      got_done.push_back('{a_frame_good, b_frame_good, a_frame_len, $time});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_fcs(input bq_t d);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (d[i])
      for (int j = 0; j < 8; j++)
        c = (c[0] ^ d[i][j]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return ~c;
  endfunction

  function automatic bq_t make_body(input bq_t d);
    bq_t         b = d;
    logic [31:0] f = model_fcs(d);
    for (int k = 0; k < 4; k++) b.push_back(f[8*k +: 8]);
    return b;
  endfunction

  task automatic put(input logic [7:0] d, input logic dv, input logic er, input logic rst);
    drv_d.push_back(d);
    drv_dv.push_back(dv);
    drv_er.push_back(er);
    drv_rst.push_back(rst);
  endtask

  task automatic put_idle(input int n);
    for (int i = 0; i < n; i++) put(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic put_frame(input int npre, input bq_t body, input int er_at, input int rst_at);
    for (int i = 0; i < npre; i++) put(8'h55, 1'b1, 1'b0, 1'b0);
    put(8'hD5, 1'b1, 1'b0, 1'b0);
    foreach (body[i]) put(body[i], 1'b1, i == er_at, i == rst_at);
  endtask

  // Forwarded bytes are everything but the trailing FCS; the verdict compares the
  // transmitted FCS against one freshly computed over the data part.
  task automatic expect_frame(input bq_t body, input logic er);
    int          n = body.size();
    bq_t         d;
    logic        fcs_ok = 1'b0;
    logic [31:0] f;
    for (int i = 0; i < n - 4; i++) begin
      d.push_back(body[i]);
      exp_b.push_back(body[i]);
      exp_s.push_back(i == 0);
    end
    if (n >= 4) begin
      f = model_fcs(d);
      fcs_ok = (f == {body[n-1], body[n-2], body[n-3], body[n-4]});
    end
    exp_done.push_back('{fcs_ok && !er && n >= 64 && n <= 1518,
                         fcs_ok && !er && n >= 1 && n <= 1518,
                         (n > 65535) ? 16'hFFFF : 16'(n), 0});
  endtask

  task automatic expect_partial(input bq_t body, input int rst_at);
    for (int i = 0; i < rst_at - 4; i++) begin
      exp_b.push_back(body[i]);
      exp_s.push_back(i == 0);
    end
  endtask

  task automatic play();
    while (drv_d.size() > 0) begin
      @(negedge clock);
      rx_data = drv_d.pop_front();
      rx_dv   = drv_dv.pop_front();
      rx_er   = drv_er.pop_front();
      reset   = drv_rst.pop_front();
      if (rx_dv) last_dv_t = $time;
    end
    @(negedge clock);
    rx_data = 8'h00; rx_dv = 1'b0; rx_er = 1'b0; reset = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  task automatic verify(input string tag);
    chk({tag, "/fwd_count"}, 32'(got_b.size()), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      chk($sformatf("%s/byte%0d", tag, i), 32'(got_b[i]), 32'(exp_b[i]));
      chk($sformatf("%s/sof%0d", tag, i), 32'(got_s[i]), 32'(exp_s[i]));
    end
    chk({tag, "/done_count"}, 32'(got_done.size()), 32'(exp_done.size()));
    for (int i = 0; i < exp_done.size() && i < got_done.size(); i++) begin
      chk($sformatf("%s/good%0d", tag, i), 32'(got_done[i].g1), 32'(exp_done[i].g1));
      chk($sformatf("%s/good_min1_%0d", tag, i), 32'(got_done[i].g2), 32'(exp_done[i].g2));
      chk($sformatf("%s/len%0d", tag, i), 32'(got_done[i].len), 32'(exp_done[i].len));
    end
    got_b.delete(); got_s.delete(); got_done.delete();
    exp_b.delete(); exp_s.delete(); exp_done.delete();
  endtask

  initial begin
    bq_t d, body, body2;
    int  er_at;

    reset = 1'b1; rx_dv = 1'b0; rx_er = 1'b0; rx_data = 8'h00; last_dv_t = 0;
    repeat (2) @(negedge clock);
    chk("reset/out_valid", 32'(a_out_valid), 32'd0);
    chk("reset/out_data", 32'(a_out_data), 32'd0);
    chk("reset/out_sof", 32'(a_out_sof), 32'd0);
    chk("reset/frame_done", 32'(a_frame_done), 32'd0);
    chk("reset/frame_good", 32'(a_frame_good), 32'd0);
    chk("reset/frame_len", 32'(a_frame_len), 32'd0);
    reset = 1'b0;
    put_idle(2);
    play();

    // Minimal legal frame
    d.delete();
    for (int i = 0; i < 60; i++) d.push_back(8'(i));
    body = make_body(d);
    put_frame(7, body, -1, -1);
    expect_frame(body, 1'b0);
    play();
    if (got_done.size() > 0)
      chk("min_good/done_latency", 32'(got_done[0].t - last_dv_t), 32'd20);
    verify("min_good");

    // Standard check vector: 13 bytes passes the residue but is runt for MIN_LEN=64
    body = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
             8'h26, 8'h39, 8'hF4, 8'hCB};
    put_frame(7, body, -1, -1);
    put_idle(1);
    expect_frame(body, 1'b0);
    play();
    verify("crc_vector");

    // Corrupted last FCS byte
    body = make_body(d);
    body[63] = 8'hFF;
    put_frame(7, body, -1, -1);
    expect_frame(body, 1'b0);
    play();
    verify("bad_fcs");

    // rx_er inside payload
    body = make_body(d);
    put_frame(7, body, 30, -1);
    expect_frame(body, 1'b1);
    play();
    verify("rx_er");

    // Framing errors: bad preamble byte, overlong preamble, dv drop in preamble
    for (int i = 0; i < 3; i++) put(8'h55, 1'b1, 1'b0, 1'b0);
    put(8'h5D, 1'b1, 1'b0, 1'b0);
    put(8'hD5, 1'b1, 1'b0, 1'b0);
    foreach (body[i]) put(body[i], 1'b1, 1'b0, 1'b0);
    put_idle(2);
    put_frame(16, body, -1, -1);
    put_idle(2);
    for (int i = 0; i < 4; i++) put(8'h55, 1'b1, 1'b0, 1'b0);
    put_idle(2);
    play();
    verify("framing");

    // Reset mid-frame, then a good frame after a single idle cycle
    for (int i = 0; i < 60; i++) d[i] = 8'($urandom);
    body = make_body(d);
    for (int i = 0; i < 60; i++) d[i] = 8'($urandom);
    body2 = make_body(d);
    put_frame(7, body, -1, 20);
    put_idle(1);
    put_frame(7, body2, -1, -1);
    expect_partial(body, 20);
    expect_frame(body2, 1'b0);
    play();
    verify("reset_mid");

    // Back-to-back good frames, then runt frames of 3 and 4 bytes
    put_frame(7, body, -1, -1);
    put_idle(1);
    put_frame(7, body2, -1, -1);
    put_idle(1);
    expect_frame(body, 1'b0);
    expect_frame(body2, 1'b0);
    chk("b2b/expected_fwd", 32'(exp_b.size()), 32'd120);
    body = '{8'h11, 8'h22, 8'h33};
    put_frame(7, body, -1, -1);
    put_idle(1);
    expect_frame(body, 1'b0);
    d.delete();
    body = make_body(d);
    put_frame(7, body, -1, -1);
    expect_frame(body, 1'b0);
    play();
    verify("b2b_runt");

    // Oversized frame is forwarded fully and flagged bad
    d.delete();
    for (int i = 0; i < 1526; i++) d.push_back(8'($urandom));
    body = make_body(d);
    put_frame(7, body, -1, -1);
    expect_frame(body, 1'b0);
    play();
    verify("oversize");

    // Random frames: random length, preamble length, corruption and rx_er
    for (int f = 0; f < 8; f++) begin
      d.delete();
      for (int i = 0; i < int'($urandom_range(0, 90)); i++) d.push_back(8'($urandom));
      body = make_body(d);
      if ($urandom_range(0, 3) == 0) begin
        er_at = int'($urandom_range(0, body.size() - 1));
        body[er_at] = body[er_at] ^ 8'h10;
      end
      er_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, body.size() - 1)) : -1;
      put_frame(int'($urandom_range(0, 15)), body, er_at, -1);
      put_idle(int'($urandom_range(1, 3)));
      expect_frame(body, er_at >= 0);
    end
    play();
    verify("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
